sine_pwm_gen: RTL

SINE_PWM_GEN -- requirements
Module: sine_pwm_gen

---
 rtl/sine_pwm_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sine_pwm_gen.sv
// rtl/sine_pwm_gen.sv - sine-weighted PWM generator driven by a phase accumulator
// Optional feature macro: SPWM_DEADTIME_EN (dead band on pwm/pwm_n).
// Ports: clk, rst (sync, active-high), en (run enable),
//        step_in/step_valid/step_ready (tuning-word handshake),
//        pwm/pwm_n (high-side/complementary PWM), sample_out (unsigned sine sample),
//        period_tick (one-cycle pulse per PWM period)
module sine_pwm_gen #(
    parameter int DW          = 8,
    parameter int LUT_AW      = 6,
    parameter int PHASE_W     = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] step_in,
    input  logic               step_valid,
    output logic               step_ready,
    output logic               pwm,
    output logic               pwm_n,
    output logic [DW-1:0]      sample_out,
    output logic               period_tick
);
    localparam int N = 1 << LUT_AW;
    // 2^DW-2: all ones except the LSB
    localparam logic [DW-1:0] TOP = {{(DW-1){1'b1}}, 1'b0};
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    if (DW < 2) begin : g_chk_dw
        $error("sine_pwm_gen: DW must be at least 2");
    end
    if (PHASE_W < LUT_AW + 2) begin : g_chk_phase
        $error("sine_pwm_gen: PHASE_W must be at least LUT_AW+2");
    end
    if (DEAD_CYCLES < 0) begin : g_chk_dead
        $error("sine_pwm_gen: DEAD_CYCLES must be non-negative");
    end

    // Quarter-wave entry round((2^(DW-1)-1)*sin(pi/2*(idx+0.5)/N)) computed in
    // Q30 fixed point with a Taylor series so the table is pure integer math.
    function automatic logic [DW-2:0] quarterSine(input int idx);
        longint scale;
        longint x;
        longint term;
        longint acc;
        longint amp;
        longint val;
        scale = 64'sd1 << 30;
        x     = (64'sd1686629713 * longint'(2 * idx + 1)) / longint'(2 * N);
        term  = x;
        acc   = x;
        for (int k = 1; k <= 12; k++) begin
            term = term * x / scale;
            term = term * x / scale;
            term = -term / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        amp = (64'sd1 << (DW - 1)) - 64'sd1;
        val = (acc * amp + scale / 2) / scale;
        return (DW-1)'(val);
    endfunction

    logic [DW-2:0] romTable [N];
    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        assign romTable[gi] = quarterSine(gi);
    end

    logic [DW-1:0]      cnt;
    logic [DW-1:0]      duty;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] step;
    logic [PHASE_W-1:0] pendingStep;
    logic               pendingValid;
    logic [DW-2:0]      romQ;
    logic               negHalf;
    logic               boundary;
    logic               raw;
    logic [1:0]         quadrant;
    logic [LUT_AW-1:0]  lutIdx;
    logic [LUT_AW-1:0]  romAddr;

    assign boundary   = en && (cnt == TOP);
    assign raw        = cnt < duty;
    assign quadrant   = phase[PHASE_W-1 -: 2];
    assign lutIdx     = phase[PHASE_W-3 -: LUT_AW];
    // Odd quadrants walk the table backwards: N-1-a is the bitwise inverse of a
    assign romAddr    = quadrant[0] ? ~lutIdx : lutIdx;
    assign step_ready = !pendingValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            phase       <= '0;
            duty        <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            if (en) begin
                cnt <= boundary ? '0 : cnt + DW'(1);
            end
            if (boundary) begin
                phase <= phase + step;
                duty  <= sample_out;
            end
        end
    end

    // A word accepted in a boundary cycle cannot be copied in that same cycle
    // (copy needs pendingValid, accept needs it clear), so it waits one period.
    always_ff @(posedge clk) begin
        if (rst) begin
            step         <= '0;
            pendingStep  <= '0;
            pendingValid <= 1'b0;
        end else if (boundary && pendingValid) begin
            step         <= pendingStep;
            pendingValid <= 1'b0;
        end else if (step_valid && !pendingValid) begin
            pendingStep  <= step_in;
            pendingValid <= 1'b1;
        end
    end

    // Two-stage sample pipeline: ROM read, then offset around mid-scale
    always_ff @(posedge clk) begin
        if (rst) begin
            romQ       <= '0;
            negHalf    <= 1'b0;
            sample_out <= '0;
        end else begin
            romQ       <= romTable[romAddr];
            negHalf    <= quadrant[1];
            sample_out <= negHalf ? MID - DW'(romQ) : MID + DW'(romQ);
        end
    end

`ifdef SPWM_DEADTIME_EN
    localparam int RUN_W = $clog2(DEAD_CYCLES + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEAD_CYCLES + 1);

    logic             rawPrev;
    logic [RUN_W-1:0] runLen;
    logic [RUN_W-1:0] runNext;

    // runNext = length of the current constant-raw run including this cycle,
    // saturating once the dead band has elapsed
    always_comb begin
        runNext = RUN_W'(1);
        if (raw == rawPrev) begin
            runNext = (runLen == RUN_MAX) ? RUN_MAX : runLen + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            rawPrev <= 1'b0;
            runLen  <= '0;
            pwm     <= 1'b0;
            pwm_n   <= 1'b0;
        end else begin
            rawPrev <= raw;
            runLen  <= runNext;
            pwm     <= raw && (runNext == RUN_MAX);
            pwm_n   <= !raw && (runNext == RUN_MAX);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pwm <= 1'b0;
        end else begin
            pwm <= raw;
        end
    end

    assign pwm_n = 1'b0;
`endif

endmodule
